// File: rtl/video_pkg.sv
// video_pkg: shared 640x480 VGA geometry, sync polarity defaults and coordinate/measurement widths
package video_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL = 525;
  localparam bit H_SYNC_ACT_LOW_DEF = 1'b1;
  localparam bit V_SYNC_ACT_LOW_DEF = 1'b1;
  localparam int COORD_W = 10;
  localparam int MEAS_W = 11;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: clk/reset(active-low sync); registers raw input normalised to asserted=1 (lvl) and flags its rise/fall
module sync_edge_detect
  import video_pkg::*;
#(
  parameter bit ACT_LOW = H_SYNC_ACT_LOW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl <= 1'b0;
      prev <= 1'b0;
    end else begin
      lvl <= raw ^ ACT_LOW;
      prev <= lvl;
    end
  end
  always_comb begin
    rise = lvl & ~prev;
    fall = ~lvl & prev;
  end
endmodule

// File: rtl/video_timing_decoder.sv
// video_timing_decoder: clk/reset(active-low sync), h_sync/v_sync/DE in; pixel_valid/x/y/line_start/frame_start, h/v total+active, locked, timing_error out
module video_timing_decoder
  import video_pkg::*;
#(
  parameter bit H_SYNC_ACT_LOW = H_SYNC_ACT_LOW_DEF,
  parameter bit V_SYNC_ACT_LOW = V_SYNC_ACT_LOW_DEF,
  parameter int LOCK_FRAMES = 3,
  parameter int LINE_TIMEOUT = 2047
) (
  input  logic clk,
  input  logic reset,
  input  logic h_sync,
  input  logic v_sync,
  input  logic DE,
  output logic pixel_valid,
  output logic [COORD_W-1:0] x_pixel,
  output logic [COORD_W-1:0] y_pixel,
  output logic line_start,
  output logic frame_start,
  output logic [MEAS_W-1:0] h_total,
  output logic [MEAS_W-1:0] v_total,
  output logic [MEAS_W-1:0] h_active,
  output logic [MEAS_W-1:0] v_active,
  output logic locked,
  output logic timing_error
);
  localparam logic [COORD_W-1:0] C_MAX = '1;
  localparam logic [MEAS_W-1:0] M_MAX = '1;
  localparam logic [MEAS_W-1:0] TMO = MEAS_W'(LINE_TIMEOUT);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  logic h_lvl, h_rise, h_fall, v_lvl, v_rise, v_fall, de_lvl, de_rise, de_fall;
  logic [MEAS_W-1:0] h_cnt, a_cnt, v_cnt, h_frm;
  logic [3:0] lock_cnt, lock_nxt;
  logic h_chk, a_chk, frame_bad, started, have_ref;
  logic h_bad, a_bad, timeout, match, unused_ok;
  sync_edge_detect #(.ACT_LOW(H_SYNC_ACT_LOW)) u_h (.clk(clk), .reset(reset), .raw(h_sync), .lvl(h_lvl), .rise(h_rise), .fall(h_fall));
  sync_edge_detect #(.ACT_LOW(V_SYNC_ACT_LOW)) u_v (.clk(clk), .reset(reset), .raw(v_sync), .lvl(v_lvl), .rise(v_rise), .fall(v_fall));
  sync_edge_detect #(.ACT_LOW(1'b0)) u_de (.clk(clk), .reset(reset), .raw(DE), .lvl(de_lvl), .rise(de_rise), .fall(de_fall));
  always_comb begin
    unused_ok = ^{h_lvl, h_fall, v_lvl, v_fall};
    h_bad = h_rise & h_chk & ~v_rise & (h_cnt != h_total);
    a_bad = de_fall & a_chk & ~v_rise & (a_cnt != h_active);
    timeout = h_cnt >= TMO;
    // the first full frame after reset has no reference, so only its line consistency qualifies it
    match = ~frame_bad & (~have_ref | ((v_cnt == v_total) & (MEAS_W'(y_pixel) == v_active) & (h_total == h_frm)));
    lock_nxt = !match ? 4'd0 : (lock_cnt >= LOCK_N) ? LOCK_N : lock_cnt + 4'd1;
    line_start = pixel_valid & (x_pixel == '0);
    frame_start = line_start & (y_pixel == '0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_valid <= 1'b0;
      x_pixel <= '0;
      y_pixel <= '0;
      h_cnt <= '0;
      a_cnt <= '0;
      v_cnt <= '0;
      h_total <= '0;
      h_active <= '0;
      v_total <= '0;
      v_active <= '0;
      h_frm <= '0;
      lock_cnt <= '0;
      locked <= 1'b0;
      timing_error <= 1'b0;
      h_chk <= 1'b0;
      a_chk <= 1'b0;
      frame_bad <= 1'b0;
      started <= 1'b0;
      have_ref <= 1'b0;
    end else begin
      pixel_valid <= de_lvl;
      x_pixel <= de_rise ? '0 : (de_lvl && x_pixel != C_MAX) ? x_pixel + 1'b1 : x_pixel;
      y_pixel <= v_rise ? '0 : (de_fall && y_pixel != C_MAX) ? y_pixel + 1'b1 : y_pixel;
      h_cnt <= h_rise ? MEAS_W'(1) : (h_cnt != M_MAX) ? h_cnt + 1'b1 : h_cnt;
      a_cnt <= de_rise ? MEAS_W'(1) : (de_lvl && a_cnt != M_MAX) ? a_cnt + 1'b1 : a_cnt;
      v_cnt <= v_rise ? MEAS_W'(h_rise) : (h_rise && v_cnt != M_MAX) ? v_cnt + 1'b1 : v_cnt;
      if (h_rise) h_total <= h_cnt;
      if (de_fall) h_active <= a_cnt;
      h_chk <= v_rise ? 1'b0 : h_rise ? 1'b1 : h_chk;
      a_chk <= v_rise ? 1'b0 : de_fall ? 1'b1 : a_chk;
      frame_bad <= v_rise ? 1'b0 : frame_bad | h_bad | a_bad;
      timing_error <= 1'b0;
      if (v_rise) begin
        v_total <= v_cnt;
        v_active <= MEAS_W'(y_pixel);
        h_frm <= h_total;
        started <= 1'b1;
        have_ref <= started;
        if (started) begin
          timing_error <= ~match;
          lock_cnt <= lock_nxt;
          locked <= lock_nxt == LOCK_N;
        end
      end
      if (timeout) begin
        lock_cnt <= '0;
        locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_decoder.sv
// tb_video_timing_decoder: directed checks of coordinates, geometry measurement and lock behaviour on a scaled-down raster
module tb_video_timing_decoder;
  import video_pkg::*;
  localparam int HT = 40, HS = 4, H0 = 6, HA = 32, VT = 12, VS = 2, V0 = 3, VA = 8;
  logic clk = 1'b0, reset, h_sync, v_sync, DE;
  logic pixel_valid, line_start, frame_start, locked, timing_error;
  logic [COORD_W-1:0] x_pixel, y_pixel;
  logic [MEAS_W-1:0] h_total, v_total, h_active, v_active;
  int total = 0, bad = 0, cyc = 0, err_pulses = 0, fs_cyc = -1, ls_cyc = -1, ls_y = -1, last_x = 0, de_on_cyc = 0, e0 = 0;
  bit pv_d = 1'b0, wrap_seen = 1'b0;
  video_timing_decoder dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
    .pixel_valid(pixel_valid), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
    .locked(locked), .timing_error(timing_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (timing_error) err_pulses++;
    if (frame_start) fs_cyc = cyc;
    if (line_start) begin
      ls_cyc = cyc;
      ls_y = int'(y_pixel);
    end
    if (pixel_valid) begin
      if (pv_d && int'(x_pixel) < last_x) wrap_seen = 1'b1;
      last_x = int'(x_pixel);
    end
    pv_d = pixel_valid;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_line(input int l, input int len);
    for (int c = 0; c < len; c++) begin
      h_sync = !(c < HS);
      v_sync = !(l < VS);
      DE = (l >= V0) && (l < V0 + VA) && (c >= H0) && (c < H0 + HA);
      if (c == H0) de_on_cyc = cyc;
      tick();
    end
  endtask
  task automatic run_frame(input int short_l);
    for (int l = 0; l < VT; l++) run_line(l, (l == short_l) ? HT - 1 : HT);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    DE = 1'b0;
    repeat (3) tick();
    total++; if ({pixel_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, h_active, v_active, locked, timing_error} !== '0) begin bad++; $display("FAIL reset_state: outputs=%h want 0", {pixel_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, h_active, v_active, locked, timing_error}); end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_lock();
    repeat (3) run_frame(-1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: locked=%0b want 0", locked); end
    run_frame(-1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_4th_edge: locked=%0b want 1", locked); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL lock_no_error: pulses=%0d want 0", err_pulses); end
    total++; if (h_total !== MEAS_W'(HT)) begin bad++; $display("FAIL h_total: got %0d want %0d", h_total, HT); end
    total++; if (v_total !== MEAS_W'(VT)) begin bad++; $display("FAIL v_total: got %0d want %0d", v_total, VT); end
    total++; if (h_active !== MEAS_W'(HA)) begin bad++; $display("FAIL h_active: got %0d want %0d", h_active, HA); end
    total++; if (v_active !== MEAS_W'(VA)) begin bad++; $display("FAIL v_active: got %0d want %0d", v_active, VA); end
  endtask
  task automatic test_alignment();
    for (int l = 0; l < 4; l++) run_line(l, HT);
    total++; if (fs_cyc !== de_on_cyc + 2) begin bad++; $display("FAIL frame_start_cycle: got %0d want %0d", fs_cyc, de_on_cyc + 2); end
    total++; if (last_x !== HA - 1) begin bad++; $display("FAIL last_x: got %0d want %0d", last_x, HA - 1); end
    run_line(4, HT);
    total++; if (ls_y !== 1) begin bad++; $display("FAIL line2_y: got %0d want 1", ls_y); end
    total++; if (ls_cyc !== de_on_cyc + 2) begin bad++; $display("FAIL line_start_cycle: got %0d want %0d", ls_cyc, de_on_cyc + 2); end
    for (int l = 5; l < VT; l++) run_line(l, HT);
  endtask
  task automatic test_short_line();
    run_frame(5);
    total++; if (err_pulses !== 0 || locked !== 1'b1) begin bad++; $display("FAIL short_before: pulses=%0d locked=%0b want 0/1", err_pulses, locked); end
    run_frame(-1);
    total++; if (err_pulses !== 1) begin bad++; $display("FAIL short_error: pulses=%0d want 1", err_pulses); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_unlock: locked=%0b want 0", locked); end
    repeat (2) run_frame(-1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early: locked=%0b want 0", locked); end
    run_frame(-1);
    total++; if (locked !== 1'b1 || err_pulses !== 1) begin bad++; $display("FAIL relock: locked=%0b pulses=%0d want 1/1", locked, err_pulses); end
  endtask
  task automatic test_timeout();
    h_sync = 1'b1;
    v_sync = 1'b1;
    DE = 1'b0;
    repeat (1950) tick();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL timeout_early: locked=%0b want 1", locked); end
    repeat (150) tick();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL timeout_unlock: locked=%0b want 0", locked); end
    total++; if (err_pulses !== 1) begin bad++; $display("FAIL timeout_no_error: pulses=%0d want 1", err_pulses); end
  endtask
  task automatic test_midframe_reset();
    for (int l = 0; l < 6; l++) run_line(l, HT);
    reset = 1'b0;
    tick();
    total++; if ({pixel_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, h_active, v_active, locked, timing_error} !== '0) begin bad++; $display("FAIL midreset_state: outputs=%h want 0", {pixel_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, h_active, v_active, locked, timing_error}); end
    reset = 1'b1;
    e0 = err_pulses;
    repeat (3) run_frame(-1);
    total++; if (locked !== 1'b0 || err_pulses !== e0) begin bad++; $display("FAIL midreset_early: locked=%0b pulses=%0d want 0/%0d", locked, err_pulses, e0); end
    run_frame(-1);
    total++; if (locked !== 1'b1 || err_pulses !== e0) begin bad++; $display("FAIL midreset_lock: locked=%0b pulses=%0d want 1/%0d", locked, err_pulses, e0); end
    total++; if (v_total !== MEAS_W'(VT) || h_total !== MEAS_W'(HT)) begin bad++; $display("FAIL midreset_geom: v=%0d h=%0d want %0d/%0d", v_total, h_total, VT, HT); end
  endtask
  task automatic test_long_de();
    h_sync = 1'b1;
    v_sync = 1'b1;
    DE = 1'b1;
    repeat (1100) tick();
    DE = 1'b0;
    repeat (4) tick();
    total++; if (x_pixel !== 10'd1023) begin bad++; $display("FAIL long_x_sat: got %0d want 1023", x_pixel); end
    total++; if (h_active !== 11'd1100) begin bad++; $display("FAIL long_h_active: got %0d want 1100", h_active); end
    total++; if (y_pixel !== COORD_W'(VA + 1)) begin bad++; $display("FAIL long_y: got %0d want %0d", y_pixel, VA + 1); end
    total++; if (wrap_seen !== 1'b0) begin bad++; $display("FAIL long_no_wrap: wrap=%0b want 0", wrap_seen); end
  endtask
  task automatic test_clear_wins();
    DE = 1'b1;
    repeat (5) tick();
    DE = 1'b0;
    v_sync = 1'b0;
    repeat (4) tick();
    total++; if (y_pixel !== '0) begin bad++; $display("FAIL clear_wins_y: got %0d want 0", y_pixel); end
    total++; if (v_active !== MEAS_W'(VA + 1)) begin bad++; $display("FAIL clear_wins_v_active: got %0d want %0d", v_active, VA + 1); end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_alignment();
    test_short_line();
    test_timeout();
    test_midframe_reset();
    test_long_de();
    test_clear_wins();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
